instr_output_sink: RTL and testbench

Output-side stage of the performance instrumentation wrapper: consumes the accelerator's output AXI-Stream, always accepts data while enabled, and produces the per-frame measurements exposed over AXI-lite. Reported values are completed-frame count, per-frame latency (input frame start to first output word), frame interval, and a tagged frame checksum. Input frame-start pulses come from the stimulus generator feeding the accelerator input, so latency is measured across the whole accelerator.

---
 rtl/instr_pkg.sv | 32 +++
 rtl/instr_stamp_fifo.sv | 56 +++++
 rtl/instr_output_sink.sv | 132 +++++++++++++
 tb/tb_instr_output_sink.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared widths, the checksum record and the per-word fold/rotate used by the
// output-side instrumentation sink.
package instr_pkg;

    localparam int CSUM_W = 24;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 32;

    // Eleven 24-bit chunks cover the widest supported output word (256 bits).
    localparam int FOLD_CHUNKS = 11;
    localparam int FOLD_MAX_W  = FOLD_CHUNKS * CSUM_W;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [CSUM_W-1:0] csum;
    } checksum_t;

    function automatic logic [CSUM_W-1:0] fold_word(input logic [FOLD_MAX_W-1:0] data);
        logic [CSUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < FOLD_CHUNKS; i++) begin
            acc = acc ^ data[i*CSUM_W +: CSUM_W];
        end
        return acc;
    endfunction

    function automatic logic [CSUM_W-1:0] csum_step(input logic [CSUM_W-1:0] acc,
                                                    input logic [FOLD_MAX_W-1:0] data);
        return {acc[CSUM_W-2:0], acc[CSUM_W-1]} ^ fold_word(data);
    endfunction

endpackage

// File: rtl/instr_stamp_fifo.sv
// Timestamp FIFO between input frame starts and output frame first words.
// Pointers carry an extra MSB so full and empty are distinguishable.
module instr_stamp_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             i_push,
    input  logic [CNT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [CNT_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: the storage array is deliberately not reset; the pointers alone define
    // which entries are valid, which keeps the array mappable onto plain RAM.
    always_ff @(posedge ap_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_output_sink.sv
// Output-side instrumentation sink: always-ready stream consumer that reports
// frame count, start-to-output latency, frame interval and a tagged checksum.
module instr_output_sink
    import instr_pkg::*;
#(
    parameter int OUT_WIDTH   = 8,
    parameter int FRAME_WORDS = 4,
    parameter int STAMP_DEPTH = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 enable,
    input  logic                 in_start,
    input  logic [OUT_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [31:0]          status_o,
    output logic [31:0]          latency,
    output logic [31:0]          interval,
    output logic [31:0]          checksum,
    output logic                 stamp_ovf,
    output logic                 stamp_udf
);

    localparam int               WCNT_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(FRAME_WORDS - 1);
    localparam logic [WCNT_W-1:0] WORD_ONE  = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    logic [CNT_W-1:0]  r_now;
    logic [WCNT_W-1:0] r_word_cnt;
    logic [CSUM_W-1:0] r_csum_acc;
    logic [IDX_W-1:0]  r_frame_idx;
    logic [CNT_W-1:0]  r_last_end;
    logic              r_have_prev;
    logic [CNT_W-1:0]  r_status;
    logic [CNT_W-1:0]  r_latency;
    logic [CNT_W-1:0]  r_interval;
    checksum_t         r_checksum;
    logic              r_stamp_ovf;
    logic              r_stamp_udf;

    logic                  w_accept;
    logic                  w_first;
    logic                  w_last;
    logic [FOLD_MAX_W-1:0] w_data_ext;
    logic [CSUM_W-1:0]     w_csum_next;
    logic [CNT_W-1:0]      w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    assign s_axis_tready = enable;
    assign w_accept      = s_axis_tvalid && enable;
    assign w_first       = w_accept && (r_word_cnt == '0);
    assign w_last        = w_accept && (r_word_cnt == WORD_LAST);
    assign w_data_ext    = FOLD_MAX_W'(s_axis_tdata);
    assign w_csum_next   = csum_step(r_csum_acc, w_data_ext);

    instr_stamp_fifo #(
        .DEPTH (STAMP_DEPTH)
    ) u_stamp_fifo (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .i_push  (in_start),
        .i_data  (r_now),
        .i_pop   (w_first),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: non-blocking assignments throughout, so every decision below sees the
    // values held before this edge regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_now       <= '0;
            r_word_cnt  <= '0;
            r_csum_acc  <= '0;
            r_frame_idx <= '0;
            r_last_end  <= '0;
            r_have_prev <= 1'b0;
            r_status    <= '0;
            r_latency   <= '0;
            r_interval  <= '0;
            r_checksum  <= '0;
            r_stamp_ovf <= 1'b0;
            r_stamp_udf <= 1'b0;
        end else begin
            r_now <= r_now + CNT_ONE;

            if (in_start && w_fifo_full) begin
                r_stamp_ovf <= 1'b1;
            end

            // An empty FIFO leaves latency untouched; a same-cycle stamp is queued, not used.
            if (w_first) begin
                if (w_fifo_empty) begin
                    r_stamp_udf <= 1'b1;
                end else begin
                    r_latency <= r_now - w_fifo_data;
                end
            end

            if (w_accept) begin
                if (w_last) begin
                    r_word_cnt  <= '0;
                    r_csum_acc  <= '0;
                    r_checksum  <= '{idx: r_frame_idx, csum: w_csum_next};
                    r_frame_idx <= r_frame_idx + IDX_ONE;
                    r_status    <= r_status + CNT_ONE;
                    r_last_end  <= r_now;
                    r_have_prev <= 1'b1;
                    if (r_have_prev) begin
                        r_interval <= r_now - r_last_end;
                    end
                end else begin
                    r_word_cnt <= r_word_cnt + WORD_ONE;
                    r_csum_acc <= w_csum_next;
                end
            end
        end
    end

    assign status_o  = r_status;
    assign latency   = r_latency;
    assign interval  = r_interval;
    assign checksum  = r_checksum;
    assign stamp_ovf = r_stamp_ovf;
    assign stamp_udf = r_stamp_udf;

endmodule

// File: tb/tb_instr_output_sink.sv
// Directed bench for instr_output_sink: checksum, latency, interval, FIFO
// boundaries, enable stall, frame index wrap and mid-frame reset.
module tb_instr_output_sink;

    localparam int OUT_WIDTH   = 8;
    localparam int FRAME_WORDS = 4;
    localparam int STAMP_DEPTH = 4;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic                 enable;
    logic                 in_start;
    logic [OUT_WIDTH-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [31:0]          status_o;
    logic [31:0]          latency;
    logic [31:0]          interval;
    logic [31:0]          checksum;
    logic                 stamp_ovf;
    logic                 stamp_udf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 ap_clk = ~ap_clk;

    instr_output_sink #(
        .OUT_WIDTH   (OUT_WIDTH),
        .FRAME_WORDS (FRAME_WORDS),
        .STAMP_DEPTH (STAMP_DEPTH)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .enable        (enable),
        .in_start      (in_start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .status_o      (status_o),
        .latency       (latency),
        .interval      (interval),
        .checksum      (checksum),
        .stamp_ovf     (stamp_ovf),
        .stamp_udf     (stamp_udf)
    );

    // After do_reset, the k-th following rising edge (k = 0, 1, ...) sees now = k.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst        = 1'b1;
        in_start      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        tick();
        tick();
        ap_rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        do_reset();
        n_checks++; if (status_o !== 32'd0) $display("FAIL rst_status: got %h want %h", status_o, 32'd0); else n_pass++;
        n_checks++; if (latency !== 32'd0) $display("FAIL rst_latency: got %h want %h", latency, 32'd0); else n_pass++;
        n_checks++; if (interval !== 32'd0) $display("FAIL rst_interval: got %h want %h", interval, 32'd0); else n_pass++;
        n_checks++; if (checksum !== 32'd0) $display("FAIL rst_checksum: got %h want %h", checksum, 32'd0); else n_pass++;
        n_checks++; if (stamp_ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", stamp_ovf); else n_pass++;
        n_checks++; if (stamp_udf !== 1'b0) $display("FAIL rst_udf: got %b want 0", stamp_udf); else n_pass++;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready_off: got %b want 0", s_axis_tready); else n_pass++;
        enable = 1'b1;
        #1;
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL tready_on: got %b want 1", s_axis_tready); else n_pass++;
    endtask

    task automatic test_checksum();
        do_reset();
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        n_checks++; if (checksum !== 32'd0) $display("FAIL csum_midframe: got %h want %h", checksum, 32'd0); else n_pass++;
        n_checks++; if (status_o !== 32'd0) $display("FAIL status_midframe: got %h want %h", status_o, 32'd0); else n_pass++;
        send_word(8'h04);
        n_checks++; if (checksum !== 32'h0000_0002) $display("FAIL csum_frame0: got %h want %h", checksum, 32'h0000_0002); else n_pass++;
        n_checks++; if (status_o !== 32'd1) $display("FAIL status_frame0: got %h want %h", status_o, 32'd1); else n_pass++;
        n_checks++; if (stamp_udf !== 1'b1) $display("FAIL udf_no_stamp: got %b want 1", stamp_udf); else n_pass++;
        n_checks++; if (latency !== 32'd0) $display("FAIL latency_held: got %h want %h", latency, 32'd0); else n_pass++;
        n_checks++; if (interval !== 32'd0) $display("FAIL interval_frame0: got %h want %h", interval, 32'd0); else n_pass++;
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        send_word(8'h04);
        n_checks++; if (checksum !== 32'h0100_0002) $display("FAIL csum_frame1: got %h want %h", checksum, 32'h0100_0002); else n_pass++;
        n_checks++; if (status_o !== 32'd2) $display("FAIL status_frame1: got %h want %h", status_o, 32'd2); else n_pass++;
        n_checks++; if (interval !== 32'd4) $display("FAIL interval_back_to_back: got %h want %h", interval, 32'd4); else n_pass++;
    endtask

    task automatic test_latency();
        int exp_lat[3];
        exp_lat = '{10, 12, 13};
        do_reset();
        pulse_start();
        repeat (14) tick();
        send_word(8'hA0);
        n_checks++; if (latency !== 32'd15) $display("FAIL latency_single: got %0d want %0d", latency, 15); else n_pass++;
        n_checks++; if (stamp_udf !== 1'b0) $display("FAIL udf_single: got %b want 0", stamp_udf); else n_pass++;
        repeat (3) send_word(8'hA1);
        // Fresh reset so the stamps below land at edges 0, 2 and 5.
        do_reset();
        pulse_start();
        tick();
        pulse_start();
        tick();
        tick();
        pulse_start();
        repeat (4) tick();
        for (int f = 0; f < 3; f++) begin
            send_word(8'h11);
            n_checks++; if (latency !== 32'(exp_lat[f])) $display("FAIL latency_fifo%0d: got %0d want %0d", f, latency, exp_lat[f]); else n_pass++;
            repeat (3) send_word(8'h22);
        end
        n_checks++; if (stamp_udf !== 1'b0) $display("FAIL udf_pending: got %b want 0", stamp_udf); else n_pass++;
    endtask

    task automatic test_interval();
        do_reset();
        repeat (37) tick();
        repeat (4) send_word(8'h55);
        n_checks++; if (interval !== 32'd0) $display("FAIL interval_first: got %0d want %0d", interval, 0); else n_pass++;
        repeat (28) tick();
        repeat (4) send_word(8'h55);
        n_checks++; if (interval !== 32'd32) $display("FAIL interval_second: got %0d want %0d", interval, 32); else n_pass++;
    endtask

    task automatic test_fifo_bounds();
        int exp_lat[4];
        exp_lat = '{10, 12, 14, 16};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_start();
            if (i == 3) begin
                n_checks++; if (stamp_ovf !== 1'b0) $display("FAIL ovf_at_full: got %b want 0", stamp_ovf); else n_pass++;
            end
            if (i == 4) begin
                n_checks++; if (stamp_ovf !== 1'b1) $display("FAIL ovf_past_full: got %b want 1", stamp_ovf); else n_pass++;
            end
            tick();
        end
        for (int f = 0; f < 5; f++) begin
            send_word(8'h33);
            if (f < 4) begin
                n_checks++; if (latency !== 32'(exp_lat[f])) $display("FAIL latency_drain%0d: got %0d want %0d", f, latency, exp_lat[f]); else n_pass++;
                n_checks++; if (stamp_udf !== 1'b0) $display("FAIL udf_drain%0d: got %b want 0", f, stamp_udf); else n_pass++;
            end else begin
                n_checks++; if (stamp_udf !== 1'b1) $display("FAIL udf_empty: got %b want 1", stamp_udf); else n_pass++;
                n_checks++; if (latency !== 32'd16) $display("FAIL latency_udf_hold: got %0d want %0d", latency, 16); else n_pass++;
            end
            repeat (3) send_word(8'h44);
        end
        n_checks++; if (status_o !== 32'd5) $display("FAIL status_drain: got %0d want %0d", status_o, 5); else n_pass++;
        n_checks++; if (stamp_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", stamp_ovf); else n_pass++;
    endtask

    task automatic test_enable_wrap();
        do_reset();
        send_word(8'h01);
        send_word(8'h02);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h03;
        enable        = 1'b0;
        #1;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL tready_disabled: got %b want 0", s_axis_tready); else n_pass++;
        repeat (20) tick();
        n_checks++; if (checksum !== 32'd0) $display("FAIL csum_stalled: got %h want %h", checksum, 32'd0); else n_pass++;
        n_checks++; if (status_o !== 32'd0) $display("FAIL status_stalled: got %h want %h", status_o, 32'd0); else n_pass++;
        enable = 1'b1;
        tick();
        s_axis_tdata = 8'h04;
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++; if (checksum !== 32'h0000_0002) $display("FAIL csum_resumed: got %h want %h", checksum, 32'h0000_0002); else n_pass++;
        n_checks++; if (status_o !== 32'd1) $display("FAIL status_resumed: got %h want %h", status_o, 32'd1); else n_pass++;
        for (int f = 1; f < 256; f++) begin
            send_word(8'h01);
            send_word(8'h02);
            send_word(8'h03);
            send_word(8'h04);
        end
        n_checks++; if (status_o !== 32'd256) $display("FAIL status_256: got %0d want %0d", status_o, 256); else n_pass++;
        n_checks++; if (checksum !== 32'hFF00_0002) $display("FAIL csum_idx_ff: got %h want %h", checksum, 32'hFF00_0002); else n_pass++;
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        send_word(8'h04);
        n_checks++; if (checksum !== 32'h0000_0002) $display("FAIL csum_idx_wrap: got %h want %h", checksum, 32'h0000_0002); else n_pass++;
        n_checks++; if (status_o !== 32'd257) $display("FAIL status_257: got %0d want %0d", status_o, 257); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        pulse_start();
        repeat (2) tick();
        send_word(8'h05);
        n_checks++; if (latency !== 32'd3) $display("FAIL latency_pre_reset: got %0d want %0d", latency, 3); else n_pass++;
        send_word(8'h06);
        send_word(8'h07);
        send_word(8'h08);
        send_word(8'h09);
        send_word(8'h09);
        send_word(8'h09);
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        n_checks++; if (status_o !== 32'd0) $display("FAIL mid_rst_status: got %h want %h", status_o, 32'd0); else n_pass++;
        n_checks++; if (latency !== 32'd0) $display("FAIL mid_rst_latency: got %h want %h", latency, 32'd0); else n_pass++;
        n_checks++; if (interval !== 32'd0) $display("FAIL mid_rst_interval: got %h want %h", interval, 32'd0); else n_pass++;
        n_checks++; if (checksum !== 32'd0) $display("FAIL mid_rst_checksum: got %h want %h", checksum, 32'd0); else n_pass++;
        n_checks++; if (stamp_udf !== 1'b0) $display("FAIL mid_rst_udf: got %b want 0", stamp_udf); else n_pass++;
        send_word(8'h10);
        send_word(8'h20);
        send_word(8'h30);
        send_word(8'h40);
        n_checks++; if (checksum !== 32'h0000_0020) $display("FAIL csum_after_rst: got %h want %h", checksum, 32'h0000_0020); else n_pass++;
        n_checks++; if (status_o !== 32'd1) $display("FAIL status_after_rst: got %h want %h", status_o, 32'd1); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        ap_rst        = 1'b1;
        enable        = 1'b0;
        in_start      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        test_reset();
        test_checksum();
        test_latency();
        test_interval();
        test_fifo_bounds();
        test_enable_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
